// File: rtl/encrypted_data_fifo_pkg.sv
// Shared widths and the ciphertext block type for the AES transmit FIFO.
package aes_fifo_pkg;
    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;

    typedef logic [BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/encrypted_data_fifo_if.sv
// Write/read handshake and status bundle between the AES stage, the FIFO and the USB transmitter.
interface encrypted_data_fifo_if #(parameter int DEPTH = 4);
    import aes_fifo_pkg::*;

    localparam int BC_W = $clog2(DEPTH*BYTES_PER_BLOCK+1);

    logic              write_enable;
    aes_block_t        write_data;
    logic              read_enable;
    logic [BYTE_W-1:0] read_data;
    logic              empty;
    logic              full;
    logic [BC_W-1:0]   byte_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write_enable, write_data, read_enable,
        input  read_data, empty, full, byte_count, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output read_data, empty, full, byte_count, overflow, underflow
    );
endinterface

// File: rtl/encrypted_data_fifo_block_byte_mux.sv
// Selects byte[idx] of a ciphertext block, byte 0 being the most significant.
module block_byte_mux
    import aes_fifo_pkg::*;
(
    input  aes_block_t        blk,
    input  logic [3:0]        idx,
    output logic [BYTE_W-1:0] byte_out
);
    aes_block_t shifted;

    assign shifted  = blk << {idx, 3'b000};
    assign byte_out = shifted[BLOCK_W-1 -: BYTE_W];
endmodule

// File: rtl/encrypted_data_fifo.sv
// Block-wide ciphertext FIFO: 128-bit pushes, byte-wide first-word-fall-through pops, MSB byte first.
module encrypted_data_fifo
    import aes_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    encrypted_data_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BC_W  = $clog2(DEPTH*BYTES_PER_BLOCK+1);

    aes_block_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        byte_idx;
    logic [CNT_W-1:0]  blk_cnt;
    logic              overflow_q;
    logic              underflow_q;

    logic              empty_w;
    logic              full_w;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_last;
    logic [BYTE_W-1:0] head_byte;

    assign empty_w = (blk_cnt == '0);
    assign full_w  = (blk_cnt == CNT_W'(DEPTH));

    // Acceptance looks only at registered flags, so a read freeing a slot cannot admit a same-cycle write.
    assign wr_ok   = bus.write_enable && !full_w;
    assign rd_ok   = bus.read_enable && !empty_w;
    assign rd_last = rd_ok && (byte_idx == 4'd15);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            byte_idx    <= '0;
            blk_cnt     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok)
                byte_idx <= byte_idx + 4'd1;
            if (rd_last)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, rd_last})
                2'b10:   blk_cnt <= blk_cnt + CNT_W'(1);
                2'b01:   blk_cnt <= blk_cnt - CNT_W'(1);
                default: blk_cnt <= blk_cnt;
            endcase
            if (bus.write_enable && full_w)
                overflow_q <= 1'b1;
            if (bus.read_enable && empty_w)
                underflow_q <= 1'b1;
        end
    end

    // Payload storage is deliberately left unreset; empty gating hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= bus.write_data;
    end

    block_byte_mux u_byte_mux (
        .blk      (mem[rd_ptr]),
        .idx      (byte_idx),
        .byte_out (head_byte)
    );

    assign bus.read_data  = empty_w ? '0 : head_byte;
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.byte_count = BC_W'({blk_cnt, 4'b0000}) - BC_W'(byte_idx);
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_encrypted_data_fifo.sv
// Directed self-checking bench for encrypted_data_fifo with DEPTH=4.
module tb_encrypted_data_fifo;
    import aes_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    encrypted_data_fifo_if #(.DEPTH(DEPTH)) bus ();

    encrypted_data_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Block k carries bytes k*16+j, so byte m of a drain starting at block 0 reads back as m.
    function automatic aes_block_t mk_blk(input int k);
        aes_block_t b;
        b = '0;
        for (int j = 0; j < 16; j++)
            b[127-8*j -: 8] = 8'(k*16 + j);
        return b;
    endfunction

    task automatic cycle(input logic we, input aes_block_t wd, input logic re);
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        aes_block_t b0;
        b0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        bus.write_enable = 1'b0;
        bus.write_data   = '0;
        bus.read_enable  = 1'b0;

        // Reset state
        #2;
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_bc", bus.byte_count, 0);
        chk("rst_rd", bus.read_data, 8'h00);
        chk("rst_ovf", bus.overflow, 1'b0);
        chk("rst_unf", bus.underflow, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single block, MSB byte first
        cycle(1'b1, b0, 1'b0);
        chk("w1_empty", bus.empty, 1'b0);
        chk("w1_bc", bus.byte_count, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b0_rd%0d", i), bus.read_data, 8'(i*8'h11));
            chk($sformatf("b0_bc%0d", i), bus.byte_count, 16 - i);
            cycle(1'b0, '0, 1'b1);
        end
        chk("b0_empty", bus.empty, 1'b1);
        chk("b0_bc_end", bus.byte_count, 0);
        chk("b0_rd_end", bus.read_data, 8'h00);
        chk("b0_unf_clean", bus.underflow, 1'b0);

        // Read while empty, then read+write while empty
        cycle(1'b0, '0, 1'b1);
        chk("unf_set", bus.underflow, 1'b1);
        chk("unf_bc", bus.byte_count, 0);
        chk("unf_empty", bus.empty, 1'b1);
        cycle(1'b1, mk_blk(5), 1'b1);
        chk("unf_wr_bc", bus.byte_count, 16);
        chk("unf_wr_rd", bus.read_data, 8'h50);

        // Fill, overflow, drain in order
        pulse_reset();
        chk("r2_unf", bus.underflow, 1'b0);
        chk("r2_empty", bus.empty, 1'b1);
        for (int k = 0; k < 4; k++)
            cycle(1'b1, mk_blk(k), 1'b0);
        chk("fill_full", bus.full, 1'b1);
        chk("fill_bc", bus.byte_count, 64);
        chk("fill_ovf0", bus.overflow, 1'b0);
        cycle(1'b1, {16{8'hEE}}, 1'b0);
        chk("ovf_set", bus.overflow, 1'b1);
        chk("ovf_bc", bus.byte_count, 64);
        chk("ovf_full", bus.full, 1'b1);
        for (int m = 0; m < 64; m++) begin
            chk($sformatf("drain_rd%0d", m), bus.read_data, 8'(m));
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_empty", bus.empty, 1'b1);
        chk("drain_ovf_sticky", bus.overflow, 1'b1);

        // Full with index 15: simultaneous read+write, write rejected
        pulse_reset();
        chk("r3_ovf", bus.overflow, 1'b0);
        for (int k = 0; k < 4; k++)
            cycle(1'b1, mk_blk(k), 1'b0);
        for (int i = 0; i < 15; i++)
            cycle(1'b0, '0, 1'b1);
        chk("f15_bc", bus.byte_count, 49);
        chk("f15_full", bus.full, 1'b1);
        chk("f15_rd", bus.read_data, 8'h0F);
        cycle(1'b1, {16{8'hEE}}, 1'b1);
        chk("f15_ovf", bus.overflow, 1'b1);
        chk("f15_bc_after", bus.byte_count, 48);
        chk("f15_full_after", bus.full, 1'b0);
        for (int m = 0; m < 48; m++) begin
            chk($sformatf("f15_rd%0d", m), bus.read_data, 8'(16 + m));
            cycle(1'b0, '0, 1'b1);
        end
        chk("f15_empty", bus.empty, 1'b1);

        // Reset mid-block discards everything
        pulse_reset();
        cycle(1'b1, mk_blk(1), 1'b0);
        cycle(1'b1, mk_blk(2), 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, '0, 1'b1);
        chk("mid_bc", bus.byte_count, 27);
        chk("mid_rd", bus.read_data, 8'h15);
        pulse_reset();
        chk("mid_rst_empty", bus.empty, 1'b1);
        chk("mid_rst_bc", bus.byte_count, 0);
        chk("mid_rst_rd", bus.read_data, 8'h00);
        cycle(1'b1, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b0);
        chk("new_rd0", bus.read_data, 8'hA0);
        chk("new_bc", bus.byte_count, 16);
        cycle(1'b1, mk_blk(3), 1'b1);
        chk("simul_bc", bus.byte_count, 31);
        chk("simul_rd", bus.read_data, 8'hA1);
        chk("simul_full", bus.full, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
